cart_mem_arbiter: RTL and testbench

//  Sequences the single cartridge SDRAM port between the HPS loader (byte writes during download) and
//  the console cartridge read port. Buffers one pending write and one pending read, issues one-cycle

---
 rtl/cart_mem_arbiter_pkg.sv | 15 +
 rtl/cart_mem_arbiter_if.sv | 23 ++
 rtl/cart_rd_cache.sv | 37 +++
 rtl/cart_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cart_mem_arbiter_pkg.sv
// Shared types for the cartridge SDRAM arbiter: FSM state encoding and the
// data pattern returned when a read has to be abandoned.
package cart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD_W,
    WAIT_W,
    CMD_R,
    WAIT_R
  } cart_state_t;

  localparam logic [7:0] CART_FILL = 8'hFF;

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// SDRAM-side command bus of the cartridge arbiter. The arbiter is the master
// (issues one-cycle commands); the SDRAM core is the slave (returns data and
// a one-cycle completion pulse).
interface cart_mem_arbiter_if #(
  parameter int AW = 25
);
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic [7:0]    mem_dout;
  logic          mem_ready;

  modport master (
    output mem_addr, mem_din, mem_we, mem_rd,
    input  mem_dout, mem_ready
  );

  modport slave (
    input  mem_addr, mem_din, mem_we, mem_rd,
    output mem_dout, mem_ready
  );
endinterface

// File: rtl/cart_rd_cache.sv
// One-entry cache of the last completed cartridge read. Only instantiated when
// the top level is built with CART_RDCACHE_EN defined.
module cart_rd_cache #(
  parameter int CAW = 20
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic [CAW-1:0] lookup_addr,
  output logic           hit,
  output logic [7:0]     hit_data,
  input  logic           upd,
  input  logic [CAW-1:0] upd_addr,
  input  logic [7:0]     upd_data,
  input  logic           inv
);
  logic           c_valid;
  logic [CAW-1:0] c_addr;
  logic [7:0]     c_data;

  assign hit      = c_valid && (c_addr == lookup_addr);
  assign hit_data = c_data;

  // Invalidation wins over a same-cycle update so stale data never survives a write.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_addr  <= '0;
      c_data  <= '0;
    end else if (inv) begin
      c_valid <= 1'b0;
    end else if (upd) begin
      c_valid <= 1'b1;
      c_addr  <= upd_addr;
      c_data  <= upd_data;
    end
  end
endmodule

// File: rtl/cart_mem_arbiter.sv
// Cartridge SDRAM arbiter: shares one SDRAM port between the HPS loader (byte
// writes) and the console cartridge read port. One buffered write and one
// buffered read; writes win. Optional read cache: define CART_RDCACHE_EN.
module cart_mem_arbiter
  import cart_arb_pkg::*;
#(
  parameter int AW      = 25,
  parameter int CAW     = 20,
  parameter int TIMEOUT = 64
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           ld_wr,
  input  logic [AW-1:0]  ld_addr,
  input  logic [7:0]     ld_data,
  output logic           ld_busy,
  output logic           ld_ovf,
  input  logic           cpu_rd,
  input  logic [CAW-1:0] cpu_addr,
  output logic [7:0]     cpu_data,
  output logic           cpu_valid,
  output logic [5:0]     cart_pages,
  output logic           err_tmo,
  cart_mem_arbiter_if.master mem
);
  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  cart_state_t    state_q, state_d;
  logic           wr_full, rd_full;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     wr_data;
  logic [CAW-1:0] rd_addr;
  logic [CW-1:0]  tmo_cnt;
  logic           take_w, take_r, done_ok, done_tmo;
  logic           wr_free, wr_accept, rd_lookup, cache_take;
  logic           rc_hit;
  logic [7:0]     rc_data;

  assign ld_busy = wr_full;

  // Next-state decode plus the slot and cache handshake strobes.
  always_comb begin
    state_d  = state_q;
    take_w   = 1'b0;
    take_r   = 1'b0;
    done_ok  = 1'b0;
    done_tmo = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_full) begin
          state_d = CMD_W;
          take_w  = 1'b1;
        end else if (rd_full) begin
          state_d = CMD_R;
          take_r  = 1'b1;
        end
      end
      CMD_W: state_d = WAIT_W;
      CMD_R: state_d = WAIT_R;
      WAIT_W, WAIT_R: begin
        if (mem.mem_ready) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          done_tmo = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_free    = (state_q == WAIT_W) && (done_ok || done_tmo);
    wr_accept  = ld_wr && (!wr_full || wr_free);
    rd_lookup  = cpu_rd && (state_q == IDLE) && !wr_full && !rd_full && !ld_wr;
    cache_take = rd_lookup && rc_hit;
  end

  // FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Write slot, overflow flag and loaded-page tracking.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_full    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      ld_ovf     <= 1'b0;
      cart_pages <= '0;
    end else begin
      if (wr_accept) begin
        wr_full    <= 1'b1;
        wr_addr    <= ld_addr;
        wr_data    <= ld_data;
        cart_pages <= ld_addr[19:14];
      end else if (wr_free) begin
        wr_full <= 1'b0;
      end
      if (ld_wr && !wr_accept) ld_ovf <= 1'b1;
    end
  end

  // Read slot; the slot is released on the edge its address is captured into
  // mem_addr, so a strobe arriving in that same cycle is kept, not lost.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_full <= 1'b0;
      rd_addr <= '0;
    end else if (cpu_rd && !cache_take) begin
      rd_full <= 1'b1;
      rd_addr <= cpu_addr;
    end else if (take_r) begin
      rd_full <= 1'b0;
    end
  end

  // Registered SDRAM command, address and write data.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem.mem_we   <= 1'b0;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_din  <= '0;
    end else begin
      mem.mem_we <= take_w;
      mem.mem_rd <= take_r;
      if (take_w) begin
        mem.mem_addr <= wr_addr;
        mem.mem_din  <= wr_data;
      end else if (take_r) begin
        mem.mem_addr <= {{(AW-CAW){1'b0}}, rd_addr};
      end
    end
  end

  // Wait-state cycle counter, cleared in the command cycle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                     tmo_cnt <= '0;
    else if (state_q == CMD_W || state_q == CMD_R) tmo_cnt <= '0;
    else if (state_q == WAIT_W || state_q == WAIT_R) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Read completion, abort fill, cache hit return and timeout pulse.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_data  <= '0;
      cpu_valid <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      cpu_valid <= 1'b0;
      err_tmo   <= done_tmo;
      if (state_q == WAIT_R && done_ok) begin
        cpu_data  <= mem.mem_dout;
        cpu_valid <= 1'b1;
      end else if (state_q == WAIT_R && done_tmo) begin
        cpu_data  <= CART_FILL;
        cpu_valid <= 1'b1;
      end else if (cache_take) begin
        cpu_data  <= rc_data;
        cpu_valid <= 1'b1;
      end
    end
  end

`ifdef CART_RDCACHE_EN
  cart_rd_cache #(.CAW(CAW)) u_rd_cache (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .lookup_addr(cpu_addr),
    .hit        (rc_hit),
    .hit_data   (rc_data),
    .upd        ((state_q == WAIT_R) && done_ok),
    .upd_addr   (mem.mem_addr[CAW-1:0]),
    .upd_data   (mem.mem_dout),
    .inv        (wr_accept || done_tmo)
  );
`else
  assign rc_hit  = 1'b0;
  assign rc_data = '0;
`endif
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Scoreboard bench for cart_mem_arbiter: expected SDRAM commands and expected
// read returns are queued by the stimulus and popped by independent monitors.
module tb_cart_mem_arbiter;
  localparam int AW  = 25;
  localparam int CAW = 20;
  localparam int TMO = 64;

  logic           clk_sys = 1'b0;
  logic           reset   = 1'b1;
  logic           ld_wr   = 1'b0;
  logic [AW-1:0]  ld_addr = '0;
  logic [7:0]     ld_data = '0;
  logic           ld_busy, ld_ovf;
  logic           cpu_rd  = 1'b0;
  logic [CAW-1:0] cpu_addr = '0;
  logic [7:0]     cpu_data;
  logic           cpu_valid;
  logic [5:0]     cart_pages;
  logic           err_tmo;

  cart_mem_arbiter_if #(.AW(AW)) mem ();

  cart_mem_arbiter #(.AW(AW), .CAW(CAW), .TIMEOUT(TMO)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ld_wr     (ld_wr),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_busy   (ld_busy),
    .ld_ovf    (ld_ovf),
    .cpu_rd    (cpu_rd),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_valid (cpu_valid),
    .cart_pages(cart_pages),
    .err_tmo   (err_tmo),
    .mem       (mem.master)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic          is_we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
  } cmd_t;

  cmd_t       cmd_q[$];
  logic [7:0] rd_q[$];
  cmd_t       cmd_e;
  logic [7:0] rd_e;

  int checks = 0;
  int errors = 0;
  int rd_seen = 0;
  int err_seen = 0;
  int cyc = 0;
  int last_cmd_cyc = 0;

  int         resp_lat  = 3;
  bit         resp_hold = 1'b0;
  logic [7:0] resp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // SDRAM model: completes each command resp_lat cycles later unless held.
  initial begin
    mem.mem_ready = 1'b0;
    mem.mem_dout  = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset && (mem.mem_we || mem.mem_rd) && !resp_hold) begin
        repeat (resp_lat) @(negedge clk_sys);
        mem.mem_dout  = resp_data;
        mem.mem_ready = 1'b1;
        @(negedge clk_sys);
        mem.mem_ready = 1'b0;
      end
    end
  end

  // Command monitor.
  always @(negedge clk_sys) begin
    if (!reset && (mem.mem_we || mem.mem_rd)) begin
      last_cmd_cyc = cyc;
      if (cmd_q.size() == 0) begin
        chk("cmd_unexpected", {30'd0, mem.mem_we, mem.mem_rd}, 32'd0);
      end else begin
        cmd_e = cmd_q.pop_front();
        chk("cmd_kind", {30'd0, mem.mem_we, mem.mem_rd}, cmd_e.is_we ? 32'd2 : 32'd1);
        chk("cmd_addr", 32'(mem.mem_addr), 32'(cmd_e.addr));
        if (cmd_e.is_we) chk("cmd_din", 32'(mem.mem_din), 32'(cmd_e.din));
      end
    end
  end

  // Read-return monitor.
  always @(negedge clk_sys) begin
    if (!reset && cpu_valid) begin
      rd_seen++;
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 32'(cpu_data), 32'h100);
      end else begin
        rd_e = rd_q.pop_front();
        chk("rd_data", 32'(cpu_data), 32'(rd_e));
      end
    end
  end

  // Timeout monitor: abort pulse lands TIMEOUT+1 cycles after the command.
  always @(negedge clk_sys) begin
    if (!reset && err_tmo) begin
      err_seen++;
      chk("tmo_latency", 32'(cyc - last_cmd_cyc), 32'(TMO + 1));
    end
  end

  task automatic push_cmd(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    cmd_t c;
    c.is_we = we;
    c.addr  = a;
    c.din   = d;
    cmd_q.push_back(c);
  endtask

  task automatic strobe(input logic w, input logic [AW-1:0] wa, input logic [7:0] wd,
                        input logic r, input logic [CAW-1:0] ra);
    @(posedge clk_sys); #1;
    ld_wr = w; ld_addr = wa; ld_data = wd;
    cpu_rd = r; cpu_addr = ra;
    @(posedge clk_sys); #1;
    ld_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic wait_rd(input int target, input int budget, input string name);
    int n = 0;
    while (rd_seen < target && n < budget) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk(name, 32'(rd_seen >= target), 32'd1);
  endtask

  task automatic wait_idle_wr(input int budget, input string name);
    int n = 0;
    while (ld_busy && n < budget) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk(name, 32'(ld_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_ld", {30'd0, ld_busy, ld_ovf}, 32'd0);
    chk("rst_cpu", {23'd0, cpu_valid, cpu_data}, 32'd0);
    chk("rst_pages_tmo", {25'd0, err_tmo, cart_pages}, 32'd0);
    chk("rst_mem_cmd", {30'd0, mem.mem_we, mem.mem_rd}, 32'd0);
    chk("rst_mem_addr", 32'(mem.mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem.mem_din), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;

    // 1: single loader write, completion 3 cycles after the command.
    push_cmd(1'b1, 25'h0004000, 8'hA5);
    strobe(1'b1, 25'h0004000, 8'hA5, 1'b0, '0);
    chk("t1_busy_set", 32'(ld_busy), 32'd1);
    @(posedge clk_sys); #1;
    chk("t1_we_latency", 32'(mem.mem_we), 32'd1);
    wait_idle_wr(20, "t1_busy_clear");
    chk("t1_pages", 32'(cart_pages), 32'd1);

    // 2: cart read returns SDRAM data.
    resp_data = 8'h3C;
    push_cmd(1'b0, 25'h0000123, 8'h00);
    rd_q.push_back(8'h3C);
    strobe(1'b0, '0, '0, 1'b1, 20'h00123);
    wait_rd(1, 20, "t2_rd_done");
    repeat (4) @(posedge clk_sys); #1;
    chk("t2_one_valid", 32'(rd_seen), 32'd1);

    // 3: simultaneous write and read; write goes first.
    resp_data = 8'h77;
    push_cmd(1'b1, 25'h0008010, 8'h5A);
    push_cmd(1'b0, 25'h0000200, 8'h00);
    rd_q.push_back(8'h77);
    strobe(1'b1, 25'h0008010, 8'h5A, 1'b1, 20'h00200);
    wait_rd(2, 30, "t3_rd_done");
    chk("t3_no_ovf", 32'(ld_ovf), 32'd0);
    chk("t3_pages", 32'(cart_pages), 32'd2);

    // 4: back-to-back loader bytes; the second is dropped.
    push_cmd(1'b1, 25'h000C000, 8'h11);
    strobe(1'b1, 25'h000C000, 8'h11, 1'b0, '0);
    ld_wr = 1'b1; ld_addr = 25'h0010000; ld_data = 8'h22;
    @(posedge clk_sys); #1;
    ld_wr = 1'b0;
    chk("t4_ovf", 32'(ld_ovf), 32'd1);
    chk("t4_pages", 32'(cart_pages), 32'd3);
    wait_idle_wr(20, "t4_busy_clear");

    // 5: read never completes; abort fills 0xFF.
    resp_hold = 1'b1;
    push_cmd(1'b0, 25'h0000055, 8'h00);
    rd_q.push_back(8'hFF);
    strobe(1'b0, '0, '0, 1'b1, 20'h00055);
    wait_rd(3, TMO + 20, "t5_abort_done");
    chk("t5_err_count", 32'(err_seen), 32'd1);
    resp_hold = 1'b0;
    repeat (2) @(posedge clk_sys); #1;

    // FSM back in IDLE: a normal read is served again.
    resp_data = 8'h3C;
    push_cmd(1'b0, 25'h0000123, 8'h00);
    rd_q.push_back(8'h3C);
    strobe(1'b0, '0, '0, 1'b1, 20'h00123);
    wait_rd(4, 20, "t5_recover_rd");
    repeat (2) @(posedge clk_sys); #1;

    // 6: repeated read of the same address.
    rd_q.push_back(8'h3C);
`ifdef CART_RDCACHE_EN
    strobe(1'b0, '0, '0, 1'b1, 20'h00123);
    chk("t6_hit_latency", 32'(cpu_valid), 32'd1);
`else
    push_cmd(1'b0, 25'h0000123, 8'h00);
    strobe(1'b0, '0, '0, 1'b1, 20'h00123);
`endif
    wait_rd(5, 20, "t6_repeat_rd");
    repeat (2) @(posedge clk_sys); #1;

    push_cmd(1'b1, 25'h0014000, 8'h99);
    strobe(1'b1, 25'h0014000, 8'h99, 1'b0, '0);
    wait_idle_wr(20, "t6_wr_done");
    resp_data = 8'h3C;
    push_cmd(1'b0, 25'h0000123, 8'h00);
    rd_q.push_back(8'h3C);
    strobe(1'b0, '0, '0, 1'b1, 20'h00123);
    wait_rd(6, 20, "t6_after_wr_rd");

    repeat (6) @(posedge clk_sys); #1;
    chk("end_cmd_q_empty", 32'(cmd_q.size()), 32'd0);
    chk("end_rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("end_err_count", 32'(err_seen), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
